// File: rtl/log_sched_pkg.sv
// Shared types and constants for the log2-unit scheduler.
// The log unit flags a zero input OVERF_CYC cycles after ISSUE and presents its result OUT_CYC cycles after ISSUE.
package log_sched_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        W1    = 3'd2,
        W2    = 3'd3,
        HOLD  = 3'd4
    } state_t;

    localparam logic SRC_E   = 1'b0;
    localparam logic SRC_MEL = 1'b1;

    localparam int LOG_IN_W  = 46;
    localparam int LOG_OUT_W = 16;

    localparam int OVERF_CYC = 1;
    localparam int OUT_CYC   = 2;

endpackage

// File: rtl/log_rr_arb.sv
// Two-way round-robin arbiter: gnt[0] = energy, gnt[1] = mel.
// The last winner loses the next tie; it resets to mel so energy wins first.
module log_rr_arb (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_e,
    input  logic       req_mel,
    input  logic       en,
    output logic [1:0] gnt
);

    logic last_mel_reg;

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (req_e && req_mel)
                gnt = last_mel_reg ? 2'b01 : 2'b10;
            else if (req_e)
                gnt = 2'b01;
            else if (req_mel)
                gnt = 2'b10;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            last_mel_reg <= 1'b1;
        else if (|gnt)
            last_mel_reg <= gnt[1];
    end

endmodule

// File: rtl/log_sched.sv
// Shares one log2 unit between the frame-energy and mel requesters and
// returns each tagged result on a valid/ready channel.
module log_sched
    import log_sched_pkg::*;
#(
    parameter int NCH   = 20,
    parameter int IDX_W = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 e_valid,
    input  logic [LOG_IN_W-1:0]  e_data,
    output logic                 e_ready,
    input  logic                 mel_valid,
    input  logic [LOG_IN_W-1:0]  mel_data,
    output logic                 mel_ready,
    output logic [LOG_IN_W-1:0]  log_in,
    output logic                 log_en,
    input  logic [LOG_OUT_W-1:0] log_out,
    input  logic                 log_overf,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [LOG_OUT_W-1:0] res_data,
    output logic                 res_src,
    output logic [IDX_W-1:0]     res_idx,
    output logic                 res_eos,
    output logic                 res_last,
    output logic                 speech_end
);

    state_t               state_reg, state_next;
    logic                 arb_en;
    logic [1:0]           gnt;
    logic                 accept;
    logic [IDX_W-1:0]     mel_idx_reg;
    logic [IDX_W-1:0]     idx_reg;
    logic                 src_reg;
    logic                 eos_reg;
    logic                 res_valid_reg;
    logic                 log_en_reg;
    logic                 speech_end_reg;
    logic [LOG_IN_W-1:0]  log_in_reg;
    logic [LOG_OUT_W-1:0] res_data_reg;

    log_rr_arb u_arb (
        .clk     (clk),
        .reset   (reset),
        .req_e   (e_valid),
        .req_mel (mel_valid),
        .en      (arb_en),
        .gnt     (gnt)
    );

    assign accept = |gnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = ISSUE;
            ISSUE:   state_next = W1;
            W1:      state_next = W2;
            W2:      state_next = HOLD;
            HOLD:    if (res_ready) state_next = accept ? ISSUE : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Readies are held low while reset is asserted so no request is lost to it.
    always_comb begin
        arb_en = 1'b0;
        if (reset) begin
            case (state_reg)
                IDLE:    arb_en = 1'b1;
                HOLD:    arb_en = res_ready;
                default: arb_en = 1'b0;
            endcase
        end
        e_ready   = gnt[0];
        mel_ready = gnt[1];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            log_in_reg     <= '0;
            log_en_reg     <= 1'b0;
            src_reg        <= SRC_E;
            idx_reg        <= '0;
            mel_idx_reg    <= '0;
            eos_reg        <= 1'b0;
            res_data_reg   <= '0;
            res_valid_reg  <= 1'b0;
            speech_end_reg <= 1'b0;
        end else begin
            log_en_reg    <= accept;
            res_valid_reg <= (state_next == HOLD);
            if (accept) begin
                log_in_reg <= gnt[1] ? mel_data : e_data;
                src_reg    <= gnt[1] ? SRC_MEL : SRC_E;
                idx_reg    <= gnt[1] ? mel_idx_reg : '0;
            end
            if (gnt[1])
                mel_idx_reg <= (mel_idx_reg == IDX_W'(NCH - 1)) ? '0 : mel_idx_reg + IDX_W'(1);
            // The unit drops its zero flag on the edge after W1, so W1 is the only sample point.
            if (state_reg == W1)
                eos_reg <= log_overf;
            if (state_reg == W2) begin
                res_data_reg <= eos_reg ? '0 : log_out;
                if (eos_reg)
                    speech_end_reg <= 1'b1;
            end
        end
    end

    assign log_in     = log_in_reg;
    assign log_en     = log_en_reg;
    assign res_valid  = res_valid_reg;
    assign res_data   = res_data_reg;
    assign res_src    = src_reg;
    assign res_idx    = idx_reg;
    assign res_eos    = eos_reg;
    assign res_last   = (src_reg == SRC_MEL) && (idx_reg == IDX_W'(NCH - 1));
    assign speech_end = speech_end_reg;

endmodule

// File: tb/tb_log_sched.sv
// Bench for log_sched: behavioural log2 unit, transaction-level reference model,
// directed scenarios followed by a randomized run.
module tb_log_sched;

    localparam int NCH   = 20;
    localparam int IDX_W = 5;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        e_valid = 1'b0, mel_valid = 1'b0, res_ready = 1'b0;
    logic [45:0] e_data = '0, mel_data = '0;
    logic        e_ready, mel_ready, log_en, res_valid, res_src, res_eos, res_last, speech_end;
    logic [45:0] log_in;
    logic [15:0] log_out = 16'h0000, res_data;
    logic        log_overf = 1'b0;
    logic [IDX_W-1:0] res_idx;

    int checks = 0;
    int failures = 0;

    log_sched #(.NCH(NCH), .IDX_W(IDX_W)) dut (
        .clk(clk), .reset(reset),
        .e_valid(e_valid), .e_data(e_data), .e_ready(e_ready),
        .mel_valid(mel_valid), .mel_data(mel_data), .mel_ready(mel_ready),
        .log_in(log_in), .log_en(log_en), .log_out(log_out), .log_overf(log_overf),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_src(res_src), .res_idx(res_idx), .res_eos(res_eos),
        .res_last(res_last), .speech_end(speech_end)
    );

    always #5 clk = ~clk;

    // log2(x)*512: integer part from the leading one, 9-bit linear fraction below it
    function automatic logic [15:0] lg(input logic [45:0] x);
        int m = 0;
        longint unsigned fr;
        for (int b = 0; b < 46; b++) if (x[b]) m = b;
        fr = ((longint'(x) - (64'd1 << m)) * 512) >> m;
        return 16'(m * 512 + int'(fr));
    endfunction

    // Log unit: zero flag valid in the cycle after log_en, result in the cycle after that
    logic        lu_s1 = 1'b0;
    logic [45:0] lu_x = '0;
    always @(posedge clk) begin
        lu_s1     <= log_en;
        if (log_en) lu_x <= log_in;
        log_overf <= log_en && (log_in == 46'd0);
        log_out   <= lu_s1 ? lg(lu_x) : 16'hBEEF;
    end

    // Reference model: cycles since accept, pending result, arbitration history
    int          m_cnt;
    bit          m_pend, m_last_mel, m_se, m_src, m_rsrc, m_reos;
    int          m_mel_idx, m_idx, m_ridx;
    logic [45:0] m_x;
    logic [15:0] m_rdata;

    bit          obs_valid, obs_log_en, obs_er, obs_mr;
    logic [15:0] obs_data;
    logic [IDX_W-1:0] obs_idx;
    int          cyc = 0;

    task automatic m_reset();
        m_cnt = 0; m_pend = 0; m_last_mel = 1; m_se = 0; m_mel_idx = 0;
        m_src = 0; m_idx = 0; m_x = '0;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step(output bit ge, output bit gm);
        bit can;
        #1;
        obs_valid = res_valid; obs_data = res_data; obs_idx = res_idx;
        obs_log_en = log_en; obs_er = e_ready; obs_mr = mel_ready;
        chk("log_en", log_en, 64'(m_cnt == 1));
        if (m_cnt == 1) chk("log_in", log_in, m_x);
        chk("res_valid", res_valid, m_pend);
        if (m_pend) begin
            chk("res_data", res_data, m_rdata);
            chk("res_src", res_src, m_rsrc);
            chk("res_idx", res_idx, 64'(m_ridx));
            chk("res_eos", res_eos, m_reos);
            chk("res_last", res_last, 64'(m_rsrc && m_ridx == NCH - 1));
        end
        chk("speech_end", speech_end, m_se);
        can = (m_cnt == 0) && (!m_pend || res_ready);
        ge  = can && e_valid && (!mel_valid || m_last_mel);
        gm  = can && mel_valid && !ge;
        chk("e_ready", e_ready, ge);
        chk("mel_ready", mel_ready, gm);
        if (m_pend && res_ready) m_pend = 0;
        if (ge || gm) begin
            m_x = gm ? mel_data : e_data;
            m_src = gm;
            m_idx = gm ? m_mel_idx : 0;
            if (gm) m_mel_idx = (m_mel_idx + 1) % NCH;
            m_last_mel = gm;
            m_cnt = 1;
        end else if (m_cnt == 3) begin
            m_cnt = 0; m_pend = 1;
            m_rdata = (m_x == 0) ? 16'h0000 : lg(m_x);
            m_rsrc = m_src; m_ridx = m_idx; m_reos = (m_x == 0);
            if (m_x == 0) m_se = 1;
        end else if (m_cnt != 0) begin
            m_cnt++;
        end
        $display("cyc=%0d er=%0b mr=%0b log_en=%0b rv=%0b rdata=%h src=%0b idx=%0d eos=%0b",
                 cyc, obs_er, obs_mr, obs_log_en, obs_valid, obs_data, res_src, obs_idx, res_eos);
        cyc++;
        @(negedge clk);
    endtask

    function automatic logic [45:0] rnd46();
        logic [63:0] r;
        r = {$urandom, $urandom};
        case ($urandom_range(0, 7))
            0:       return 46'd0;
            1:       return 46'(r[15:0]);
            default: return r[45:0];
        endcase
    endfunction

    task automatic chk_zero(input string tag);
        #1;
        chk({tag, "_e_ready"}, e_ready, 0);
        chk({tag, "_mel_ready"}, mel_ready, 0);
        chk({tag, "_log_in"}, log_in, 0);
        chk({tag, "_log_en"}, log_en, 0);
        chk({tag, "_res_valid"}, res_valid, 0);
        chk({tag, "_res_data"}, res_data, 0);
        chk({tag, "_res_src"}, res_src, 0);
        chk({tag, "_res_idx"}, res_idx, 0);
        chk({tag, "_res_eos"}, res_eos, 0);
        chk({tag, "_res_last"}, res_last, 0);
        chk({tag, "_speech_end"}, speech_end, 0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        chk_zero("reset");
        m_reset();
        repeat (2) @(negedge clk);
        e_valid = 0; mel_valid = 0;
        reset = 1'b1;
        @(negedge clk);
    endtask

    // One request from idle with res_ready high; directed check on the returned result
    task automatic single(input bit mel, input logic [45:0] d, input logic [15:0] exp_data,
                          input string tag);
        bit ge, gm;
        int n = 0;
        if (mel) begin mel_valid = 1; mel_data = d; end
        else begin e_valid = 1; e_data = d; end
        step(ge, gm);
        e_valid = 0; mel_valid = 0;
        obs_valid = 0;
        while (!obs_valid && n < 8) begin step(ge, gm); n++; end
        chk({tag, "_valid"}, obs_valid, 1);
        chk({tag, "_data"}, obs_data, exp_data);
        chk({tag, "_lat"}, n, 4);
    endtask

    initial begin
        bit ge, gm;
        int last_en, seq, k;

        m_reset();
        e_valid = 1; mel_valid = 1;
        repeat (2) @(negedge clk);
        do_reset();
        res_ready = 1;

        // Energy: 2^20 and 3 give exact literals; zero raises end of speech
        single(0, 46'd1 << 20, 16'h2800, "e_2p20");
        single(0, 46'd3, 16'h0300, "e_3");
        single(0, 46'd0, 16'h0000, "e_zero");
        chk("speech_end_set", speech_end, 1);
        single(0, 46'd1000, lg(46'd1000), "e_after_eos");
        chk("speech_end_sticky", speech_end, 1);

        // 25 back-to-back mel samples
        mel_valid = 1; mel_data = rnd46();
        last_en = -1; seq = 0; k = 0;
        for (int c = 0; c < 120 && seq < 25; c++) begin
            step(ge, gm);
            if (gm) begin k++; if (k < 25) mel_data = rnd46(); else mel_valid = 0; end
            if (obs_log_en) begin
                if (last_en >= 0) chk("en_spacing", cyc - 1 - last_en, 4);
                last_en = cyc - 1;
            end
            if (obs_valid) begin chk("mel_seq_idx", obs_idx, seq % NCH); seq++; end
        end
        chk("mel_seq_count", seq, 25);
        mel_valid = 0;
        repeat (3) step(ge, gm);

        // Both requesters held from reset: E, M, E, M ...
        do_reset();
        e_valid = 1; e_data = rnd46(); mel_valid = 1; mel_data = rnd46();
        k = 0;
        for (int c = 0; c < 40; c++) begin
            step(ge, gm);
            if (obs_er || obs_mr) begin chk("alt_src", obs_mr, k % 2); k++; end
            if (ge) e_data = rnd46();
            if (gm) mel_data = rnd46();
        end
        chk("alt_count", k >= 8, 1);
        e_valid = 0; mel_valid = 0;
        repeat (6) step(ge, gm);

        // Consumer stall in HOLD with a mel request waiting, then same-cycle accept
        res_ready = 0;
        e_valid = 1; e_data = rnd46();
        step(ge, gm);
        e_valid = 0;
        for (int c = 0; c < 8 && !m_pend; c++) step(ge, gm);
        mel_valid = 1; mel_data = rnd46();
        repeat (10) step(ge, gm);
        chk("stall_hold_valid", obs_valid, 1);
        res_ready = 1;
        step(ge, gm);
        chk("stall_accept", obs_mr, 1);
        mel_valid = 0;
        step(ge, gm);
        chk("stall_log_en", obs_log_en, 1);
        repeat (5) step(ge, gm);

        // Reset during W1 of a mel request
        single(1, 46'd77, lg(46'd77), "pre_rst_mel0");
        single(1, 46'd99, lg(46'd99), "pre_rst_mel1");
        mel_valid = 1; mel_data = 46'd12345;
        step(ge, gm);
        step(ge, gm);
        do_reset();
        single(1, 46'd5, lg(46'd5), "post_rst_mel");
        chk("post_rst_idx", obs_idx, 0);

        // Randomized traffic
        for (int c = 0; c < 500; c++) begin
            if (!e_valid && $urandom_range(0, 2) == 0) begin e_valid = 1; e_data = rnd46(); end
            else if (e_valid && $urandom_range(0, 15) == 0) e_valid = 0;
            if (!mel_valid && $urandom_range(0, 1) == 0) begin mel_valid = 1; mel_data = rnd46(); end
            else if (mel_valid && $urandom_range(0, 15) == 0) mel_valid = 0;
            res_ready = ($urandom_range(0, 3) != 0);
            step(ge, gm);
            if (ge) e_valid = 0;
            if (gm) mel_valid = 0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/log_sched.md
Name: log_sched

Overview:
- Scheduler that shares the single log2 unit between two requesters: the frame-energy adder (one value per frame) and the mel filterbank stream (NCH values per frame).
- Arbitrates between them, issues the one-cycle enable to the log unit, and captures its end-of-speech flag and result at the correct cycles.
- Presents each result on one tagged output channel with valid/ready handshake.
- Sits between eadder/melfft and the feature extractor back-end.

Parameters:
- NCH, 20, mel channels per frame.
- IDX_W, 5, width of the channel index; must satisfy 2^IDX_W >= NCH.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- e_valid  in  1  energy request valid.
- e_data  in  46  energy value.
- e_ready  out  1  energy request accepted this cycle.
- mel_valid  in  1  mel request valid.
- mel_data  in  46  mel energy value.
- mel_ready  out  1  mel request accepted this cycle.
- log_in  out  46  operand to the log unit (registered).
- log_en  out  1  log unit enable (registered, one-cycle pulse).
- log_out  in  16  log unit result, log2(x)*512.
- log_overf  in  1  log unit zero-input (end-of-speech) flag.
- res_valid  out  1  result valid.
- res_ready  in  1  consumer accepts the result.
- res_data  out  16  log result.
- res_src  out  1  0 = energy, 1 = mel.
- res_idx  out  IDX_W  mel channel index; 0 when res_src = 0.
- res_eos  out  1  input was zero.
- res_last  out  1  res_src = 1 and res_idx = NCH-1.
- speech_end  out  1  sticky end-of-speech; cleared only by reset.

Behaviour:
- Reset values: all outputs 0; state IDLE; mel_idx 0; last_grant = mel, so energy wins the first contention.
- States and transitions:
  - IDLE: accept a request if one is pending.
  - ISSUE: log_en = 1 and log_in is stable. Unconditionally -> W1.
  - W1: register log_overf into an eos flag. Unconditionally -> W2.
  - W2: log_out is valid. Capture res_data = eos ? 16'h0000 : log_out. Set res_valid. -> HOLD.
  - HOLD: res_valid = 1 and all res_* outputs are stable. On res_ready, either accept a new request the same cycle (-> ISSUE) or go -> IDLE with res_valid cleared.
- Accept rule: the ready of exactly one requester is asserted combinationally, only in IDLE, or in HOLD with res_ready = 1.
- Arbitration:
  - Only one valid: grant it.
  - Both valid: grant the one not in last_grant, then update last_grant.
- On accept:
  - log_in <= data; latch src.
  - Latch idx <= mel_idx for mel requests; 0 for energy.
  - A mel accept advances mel_idx, wrapping from NCH-1 to 0.
- Latency: res_valid rises 4 cycles after the accept cycle. Back-to-back throughput with res_ready held high is one result per 4 cycles.
- log_en spacing is 4 or more cycles. This guarantees the log unit is in its decode state whenever log_en is asserted.
- log_overf is sampled only in W1 (the unit clears it on the next edge). log_out is sampled only in W2. Both inputs are ignored in all other states.
- End of speech: eos = 1 gives res_eos = 1 and res_data = 0, and sets speech_end. Scheduling continues normally afterwards.
- res_last is combinational from the latched src and idx.
- No request pending: stay in IDLE with log_en = 0.
- Reset mid-operation: immediate return to the reset values. Any in-flight result is discarded and mel_idx returns to 0.
- A requester must hold valid and data stable until its ready is asserted. Dropping valid while unaccepted is allowed; no grant is made for it.

Decomposition:
- Package log_sched_pkg:
  - State enum (IDLE, ISSUE, W1, W2, HOLD).
  - SRC_E = 0 and SRC_MEL = 1.
  - LOG_IN_W = 46, LOG_OUT_W = 16.
  - Sample offsets OVERF_CYC = 1 and OUT_CYC = 2, counted after ISSUE.
- One sub-module: log_rr_arb, a two-way round-robin arbiter.
  - Inputs: two valids and an enable.
  - Outputs: a one-hot grant.
  - Internal: the last_grant register.

Test Plan:
- Single energy request, e_data = 2^20 with log unit attached, res_ready = 1 -> log_en pulses 1 cycle after accept; res_valid 4 cycles after accept; res_data = 0x2800, res_src = 0, res_eos = 0.
- e_data = 3 -> res_data = 0x0300. e_data = 0 -> res_eos = 1, res_data = 0x0000, speech_end = 1 and stays 1 through later requests.
- 25 consecutive mel samples -> res_idx 0..19 then 0..4; res_last = 1 only at idx 19; log_en pulses exactly 4 cycles apart.
- e_valid and mel_valid held together from reset -> grants alternate E, M, E, M. The energy grant carries res_idx = 0, and mel indices still increment by 1 per mel grant.
- res_ready low for 10 cycles in HOLD -> res_* stable, no log_en, both readies low. Raising res_ready with a pending request -> same-cycle accept, and log_en pulses in the following cycle.
- Assert reset during W1 of a mel request -> all outputs 0 and mel_idx = 0. The next mel result after reset has res_idx = 0.
